key_source_arbiter: RTL and testbench
=====================================

Name: key_source_arbiter

Overview:
- Shares the single 8-bit key-code channel into game logic between two requesters: the physical PS/2 keyboard controller (KB) and the scripted/fake key generator (SC).
- Arbitrates per-cycle grants and buffers accepted codes in a small first-word-fall-through FIFO.
- Presents codes to the consumer through a valid/ready handshake.
- Code 0x00 is the idle code throughout the codebase; it is never forwarded.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, log2(DEPTH).
- HOLDOFF, 8'd254, cycles SC stays blocked after a KB grant (only with the optional feature).

Ports:
- clk_25mhz  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- kb_valid  in  1  KB request; held until kb_ack.
- kb_code  in  8  KB key code; stable while kb_valid.
- kb_ack  out  1  KB grant, combinational, single cycle.
- sc_valid  in  1  SC request; held until sc_ack.
- sc_code  in  8  SC key code; stable while sc_valid.
- sc_ack  out  1  SC grant, combinational, single cycle.
- out_valid  out  1  FIFO non-empty.
- out_code  out  8  FIFO head code; 0x00 when empty.
- out_ready  in  1  consumer accepts the head.
- fifo_count  out  AW+1  occupancy, 0..DEPTH.
- last_src  out  1  source of the most recent grant; 0=KB, 1=SC.

Behaviour:
- Reset: asynchronous on reset_n low. Resets read pointer, write pointer, count, round-robin pointer and holdoff counter.
  - After reset: out_valid=0, out_code=0x00, fifo_count=0, last_src=0, kb_ack=0, sc_ack=0.
  - FIFO storage is not cleared.
  - Reset mid-transfer discards all buffered codes. Any request pending at that moment is re-arbitrated after release.
- Grant eligibility: requires fifo_count<DEPTH. A pop in the same cycle does not make a full FIFO eligible.
  - At most one grant per cycle.
  - The ack is asserted in the same cycle as the grant.
  - The requester advances on the clock edge where its ack is high.
- Round-robin:
  - rr_ptr=0 means KB has priority; rr_ptr=1 means SC has priority.
  - Only one requester valid: it wins.
  - Both valid: the prioritised source wins.
  - After any grant, rr_ptr points to the loser.
  - rr_ptr resets to 0.
- Zero codes: a granted code of 0x00 is acked but not written. Count is unchanged; rr_ptr and last_src still update.
- Push: write code at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: on out_valid & out_ready, rd_ptr increments modulo DEPTH. out_ready while empty is ignored.
- Simultaneous push and pop with count>0: count is unchanged and both pointers advance.
- Latency: a code granted in cycle N is visible at out_code with out_valid=1 in cycle N+1 when the FIFO was empty.
- No state machine beyond the pointers: the arbiter is stateless except rr_ptr and the holdoff counter.

Optional Feature:
KEY_SRC_KB_OVERRIDE_EN
- Defined:
  - KB has strict priority; rr_ptr is ignored.
  - Every KB grant loads an 8-bit holdoff counter with HOLDOFF.
  - The counter decrements each cycle while non-zero.
  - SC is ineligible while the counter is non-zero.
  - A KB grant while the counter is non-zero reloads it.
  - The counter resets to 0.
- Undefined: pure round-robin as above; HOLDOFF is unused and no counter is synthesised.

Test Plan:
- Reset then idle: reset_n low→high, no requests → out_valid=0, out_code=0x00, fifo_count=0, both acks 0.
- Contention fairness: kb_valid=1 (0x1C) and sc_valid=1 (0x35) from cycle 0, each source advancing its code on ack → acks alternate KB,SC,KB,SC; out_code order 0x1C,0x35,… with out_ready=1.
- Full FIFO: DEPTH=4, out_ready=0, SC sends 0x35,0x09,0x04,0x3B → fifo_count=4; next request gets no ack until one pop, then ack one cycle after the pop.
- Zero drop: SC sends 0x00 then 0x38 → both acked, fifo_count reaches 1 only, out_code=0x38.
- Mid-operation reset: 3 entries buffered, reset_n pulsed low for 1 cycle → fifo_count=0, out_valid=0 immediately (async); a held request is acked after release.
- With KEY_SRC_KB_OVERRIDE_EN: KB grants 0x1C at cycle 10 while sc_valid is held → sc_ack stays 0 for HOLDOFF=254 cycles, then asserts.

Source files
------------

// File: rtl/key_source_arbiter.sv
// Two-source (KB/SC) key-code arbiter feeding a small FWFT FIFO; codes of 0x00 are acked but dropped.
// Latency: a grant in cycle N is visible on out_code/out_valid in cycle N+1 when the FIFO was empty.
// Backpressure: no grant while the FIFO is full; `KEY_SRC_KB_OVERRIDE_EN gives KB strict priority plus SC holdoff.
module key_source_arbiter #(
    parameter int         DEPTH   = 4,
    parameter int         AW      = 2,
    parameter logic [7:0] HOLDOFF = 8'd254
) (
    input  logic          clk_25mhz,
    input  logic          reset_n,
    input  logic          kb_valid,
    input  logic [7:0]    kb_code,
    output logic          kb_ack,
    input  logic          sc_valid,
    input  logic [7:0]    sc_code,
    output logic          sc_ack,
    output logic          out_valid,
    output logic [7:0]    out_code,
    input  logic          out_ready,
    output logic [AW:0]   fifo_count,
    output logic          last_src
);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          last_src_q, last_src_d;
    logic          eligible, kb_win, sc_win, grant, push, pop;
    logic [7:0]    grant_code;

    // Acks are gated by reset so a request held through reset is re-arbitrated after release.
    assign eligible = reset_n & (count_q != FULL_C);

`ifdef KEY_SRC_KB_OVERRIDE_EN
    logic [7:0] holdoff_q, holdoff_d;

    always_comb begin
        kb_win    = eligible & kb_valid;
        sc_win    = eligible & sc_valid & ~kb_valid & (holdoff_q == 8'd0);
        holdoff_d = holdoff_q;
        if (kb_win)
            holdoff_d = HOLDOFF;
        else if (holdoff_q != 8'd0)
            holdoff_d = holdoff_q - 8'd1;
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n)
            holdoff_q <= 8'd0;
        else
            holdoff_q <= holdoff_d;
    end
`else
    wire unused_holdoff = ^HOLDOFF;

    always_comb begin
        kb_win = eligible & kb_valid & (~sc_valid | ~rr_ptr_q);
        sc_win = eligible & sc_valid & (~kb_valid | rr_ptr_q);
    end
`endif

    always_comb begin
        grant      = kb_win | sc_win;
        grant_code = kb_win ? kb_code : sc_code;
        push       = grant & (grant_code != 8'h00);
        pop        = (count_q != '0) & out_ready;

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        rr_ptr_d   = rr_ptr_q;
        last_src_d = last_src_q;
        if (grant) begin
            rr_ptr_d   = kb_win;
            last_src_d = sc_win;
        end
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= 1'b0;
            last_src_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            last_src_q <= last_src_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk_25mhz) begin
        if (push)
            mem_q[wr_ptr_q] <= grant_code;
    end

    assign kb_ack     = kb_win;
    assign sc_ack     = sc_win;
    assign out_valid  = (count_q != '0);
    assign out_code   = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign last_src   = last_src_q;

endmodule

// File: tb/tb_key_source_arbiter.sv
// Randomized and directed bench for key_source_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_key_source_arbiter;
    localparam int         DEPTH   = 4;
    localparam int         AW      = 2;
    localparam logic [7:0] HOLDOFF = 8'd254;

    logic        clk_25mhz = 1'b0;
    logic        reset_n   = 1'b0;
    logic        kb_valid  = 1'b0;
    logic [7:0]  kb_code   = 8'h00;
    logic        kb_ack;
    logic        sc_valid  = 1'b0;
    logic [7:0]  sc_code   = 8'h00;
    logic        sc_ack;
    logic        out_valid;
    logic [7:0]  out_code;
    logic        out_ready = 1'b0;
    logic [AW:0] fifo_count;
    logic        last_src;

    key_source_arbiter #(.DEPTH(DEPTH), .AW(AW), .HOLDOFF(HOLDOFF)) dut (
        .clk_25mhz (clk_25mhz),
        .reset_n   (reset_n),
        .kb_valid  (kb_valid),
        .kb_code   (kb_code),
        .kb_ack    (kb_ack),
        .sc_valid  (sc_valid),
        .sc_code   (sc_code),
        .sc_ack    (sc_ack),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_ready (out_ready),
        .fifo_count(fifo_count),
        .last_src  (last_src)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int n_chk  = 0;
    int n_fail = 0;

    // Requester code streams; each source presents the head until acked.
    logic [7:0] kb_src[$];
    logic [7:0] sc_src[$];

    // Reference model: FIFO contents, who has priority next, last winner, cycle of last KB grant.
    logic [7:0] mq[$];
    bit         m_prio_sc;
    bit         m_last;
    int         cyc;
    int         last_kb_cyc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prio_sc   = 1'b0;
        m_last      = 1'b0;
        last_kb_cyc = -100000;
    endtask

    task automatic drive();
        kb_valid = (kb_src.size() != 0);
        kb_code  = kb_valid ? kb_src[0] : 8'h00;
        sc_valid = (sc_src.size() != 0);
        sc_code  = sc_valid ? sc_src[0] : 8'h00;
    endtask

    // One clock: check outputs mid-cycle, commit the model on the edge, then advance the sources.
    task automatic cycle();
        bit ekb, esc, room;
        logic [7:0] head;
        @(negedge clk_25mhz);
        room = (mq.size() < DEPTH);
`ifdef KEY_SRC_KB_OVERRIDE_EN
        ekb = room && kb_valid;
        esc = room && sc_valid && !kb_valid && (cyc - last_kb_cyc > int'(HOLDOFF));
`else
        if (kb_valid && sc_valid) begin
            ekb = room && !m_prio_sc;
            esc = room &&  m_prio_sc;
        end else begin
            ekb = room && kb_valid;
            esc = room && sc_valid;
        end
`endif
        head = (mq.size() != 0) ? mq[0] : 8'h00;
        check_eq("kb_ack",     32'(kb_ack),     32'(ekb));
        check_eq("sc_ack",     32'(sc_ack),     32'(esc));
        check_eq("out_valid",  32'(out_valid),  32'(mq.size() != 0));
        check_eq("out_code",   32'(out_code),   32'(head));
        check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check_eq("last_src",   32'(last_src),   32'(m_last));
        @(posedge clk_25mhz);
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (ekb) begin
            if (kb_code != 8'h00) mq.push_back(kb_code);
            m_prio_sc   = 1'b1;
            m_last      = 1'b0;
            last_kb_cyc = cyc;
        end else if (esc) begin
            if (sc_code != 8'h00) mq.push_back(sc_code);
            m_prio_sc = 1'b0;
            m_last    = 1'b1;
        end
        cyc++;
        #1;
        if (ekb) void'(kb_src.pop_front());
        if (esc) void'(sc_src.pop_front());
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called just after a rising edge; checks the asynchronous clear before the next edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
        check_eq("rst_out_valid",  32'(out_valid),  32'd0);
        check_eq("rst_out_code",   32'(out_code),   32'd0);
        check_eq("rst_kb_ack",     32'(kb_ack),     32'd0);
        check_eq("rst_sc_ack",     32'(sc_ack),     32'd0);
        check_eq("rst_last_src",   32'(last_src),   32'd0);
        model_reset();
        @(posedge clk_25mhz);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] c;
        c = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        return c;
    endfunction

    initial begin
        cyc = 0;
        model_reset();
        @(posedge clk_25mhz);
        #1;
        do_reset();

        // Idle after reset.
        run(4);

        // Contention: both sources held from the start, each advancing its code on ack.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kb_src.push_back(8'h1C + 8'(i));
            sc_src.push_back(8'h35 + 8'(i));
        end
        drive();
        run(12);

        // Full FIFO: four SC codes with no consumer, then a fifth that must wait for a pop.
        out_ready = 1'b0;
        sc_src    = '{8'h35, 8'h09, 8'h04, 8'h3B, 8'h22};
        drive();
        run(8);
        out_ready = 1'b1;
        run(1);
        out_ready = 1'b0;
        run(3);
        out_ready = 1'b1;
        run(6);

        // Zero code is acked but never buffered.
        out_ready = 1'b0;
        sc_src    = '{8'h00, 8'h38};
        drive();
        run(4);
        out_ready = 1'b1;
        run(3);

        // Reset with three entries buffered and a KB request arriving alongside the reset.
        out_ready = 1'b0;
        sc_src    = '{8'h11, 8'h12, 8'h13};
        drive();
        run(5);
        kb_src.push_back(8'h44);
        drive();
        do_reset();
        run(4);
        out_ready = 1'b1;
        run(3);

`ifdef KEY_SRC_KB_OVERRIDE_EN
        // KB grant blocks a held SC request for the holdoff window.
        kb_src.push_back(8'h1C);
        sc_src.push_back(8'h35);
        drive();
        run(int'(HOLDOFF) + 16);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (kb_src.size() == 0 && $urandom_range(0, 2) == 0) kb_src.push_back(rand_code());
            if (sc_src.size() == 0 && $urandom_range(0, 2) == 0) sc_src.push_back(rand_code());
            out_ready = ($urandom_range(0, 3) != 0);
            drive();
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
